// File: rtl/rv32_mem_pkg.sv
// rv32_mem_pkg: funct3 codes, responder states and request error check shared by the data-memory path
package rv32_mem_pkg;
  localparam logic [2:0] F3_LB = 3'b000, F3_LH = 3'b001, F3_LW = 3'b010, F3_LBU = 3'b100, F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB = 3'b000, F3_SH = 3'b001, F3_SW = 3'b010;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
  function automatic logic req_err(input logic we, input logic [2:0] f3, input logic [31:0] addr, input int unsigned aw);
    logic illegal, misaligned, out_of_range;
    illegal = we ? (f3 > 3'd2) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    misaligned = f3[1:0] == 2'b01 ? addr[0] : f3[1:0] == 2'b10 ? (addr[1:0] != 2'b00) : 1'b0;
    out_of_range = (addr >> (aw + 2)) != 32'd0;
    return illegal | misaligned | out_of_range;
  endfunction
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request and response valid/ready channels between core and data memory
interface dmem_responder_if;
  logic req_valid, req_ready, req_we;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  modport master(output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
                 input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
                output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store byte enables and lane replication, load byte/half extraction and extension
module lsu_lane_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0] w_byte;
  logic [15:0] w_half;
  assign w_byte = i_rword[{i_offset, 3'b000} +: 8];
  assign w_half = i_offset[1] ? i_rword[31:16] : i_rword[15:0];
  // replicating the data across lanes lets the enables alone pick the target lane
  assign o_be = i_funct3[1:0] == 2'b00 ? 4'b0001 << i_offset :
                i_funct3[1:0] == 2'b01 ? (i_offset[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign o_wdata = i_funct3[1:0] == 2'b00 ? {4{i_wdata[7:0]}} :
                   i_funct3[1:0] == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
  assign o_rdata = i_funct3 == F3_LB  ? {{24{w_byte[7]}}, w_byte} :
                   i_funct3 == F3_LH  ? {{16{w_half[15]}}, w_half} :
                   i_funct3 == F3_LW  ? i_rword :
                   i_funct3 == F3_LBU ? {24'd0, w_byte} :
                   i_funct3 == F3_LHU ? {16'd0, w_half} : 32'd0;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding RV32I load/store responder with configurable wait states
module dmem_responder
  import rv32_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  dmem_responder_if.slave bus
);
  localparam int CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
  logic [31:0] r_mem [2**ADDR_WIDTH];
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic r_we, r_req_ready, r_rsp_valid, r_err;
  logic [2:0] r_f3;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic w_err;
  logic [3:0] w_be;
  logic [31:0] w_wdata, w_rdata, w_rword;
  assign w_idx = r_addr[ADDR_WIDTH+1:2];
  assign w_err = req_err(r_we, r_f3, r_addr, ADDR_WIDTH);
  assign w_rword = r_mem[w_idx];
  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err = r_err;
  lsu_lane_align u_align (
    .i_funct3(r_f3),
    .i_offset(r_addr[1:0]),
    .i_wdata(r_wdata),
    .i_rword(w_rword),
    .o_be(w_be),
    .o_wdata(w_wdata),
    .o_rdata(w_rdata)
  );
  // a reset edge landing in ACCESS must not commit the store
  always_ff @(posedge clk)
    if (!reset && r_state == ACCESS && r_we && !w_err)
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.req_valid) begin
          r_we <= bus.req_we;
          r_f3 <= bus.req_funct3;
          r_addr <= bus.req_addr;
          r_wdata <= bus.req_wdata;
          r_req_ready <= 1'b0;
          r_cnt <= CW'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
          r_state <= WAIT_CYCLES > 0 ? WAIT : ACCESS;
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= ACCESS;
        end
        ACCESS: begin
          r_rdata <= (w_err || r_we) ? 32'd0 : w_rdata;
          r_err <= w_err;
          r_rsp_valid <= 1'b1;
          r_state <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed load/store vectors against a 2-wait-state and a zero-wait-state responder
module tb_dmem_responder;
  import rv32_mem_pkg::*;
  logic clk = 0, reset = 1;
  logic [1:0] req_valid = '0, req_we = '0, rsp_ready = '0;
  logic [1:0] req_ready, rsp_valid, rsp_err;
  logic [2:0] req_funct3 [2];
  logic [31:0] req_addr [2], req_wdata [2], rsp_rdata [2];
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  dmem_responder_if bus [2] ();
  for (genvar g = 0; g < 2; g++) begin : g_conn
    assign bus[g].req_valid = req_valid[g];
    assign bus[g].req_we = req_we[g];
    assign bus[g].req_funct3 = req_funct3[g];
    assign bus[g].req_addr = req_addr[g];
    assign bus[g].req_wdata = req_wdata[g];
    assign bus[g].rsp_ready = rsp_ready[g];
    assign req_ready[g] = bus[g].req_ready;
    assign rsp_valid[g] = bus[g].rsp_valid;
    assign rsp_rdata[g] = bus[g].rsp_rdata;
    assign rsp_err[g] = bus[g].rsp_err;
  end
  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut0 (.clk(clk), .reset(reset), .bus(bus[0]));
  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut1 (.clk(clk), .reset(reset), .bus(bus[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    req_we[d] = we; req_funct3[d] = f3; req_addr[d] = a; req_wdata[d] = wd; req_valid[d] = 1;
    while (!req_ready[d] && n < 50) begin tick(); n++; end
    chk("accept", {31'd0, req_ready[d]}, 32'd1);
    tick();
    req_valid[d] = 0;
  endtask

  task automatic wait_rsp(input int d, output int n);
    n = 0;
    while (!rsp_valid[d] && n < 50) begin tick(); n++; end
  endtask

  task automatic txn(input int d, input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input string tag);
    int n;
    rsp_ready[d] = 1;
    issue(d, we, f3, a, wd);
    wait_rsp(d, n);
    chk({tag, ".lat"}, n, d == 0 ? 32'd3 : 32'd1);
    chk({tag, ".rd"}, rsp_rdata[d], exp_rd);
    chk({tag, ".err"}, {31'd0, rsp_err[d]}, {31'd0, exp_err});
    tick();
    chk({tag, ".done"}, {31'd0, rsp_valid[d]}, 32'd0);
  endtask

  initial begin
    int n;
    req_funct3[0] = 0; req_funct3[1] = 0;
    req_addr[0] = 0; req_addr[1] = 0; req_wdata[0] = 0; req_wdata[1] = 0;
    repeat (3) tick();
    reset = 0;
    chk("rst.req_ready", {31'd0, req_ready[0]}, 32'd1);
    chk("rst.rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("rst.rdata", rsp_rdata[0], 32'd0);
    chk("rst.err", {31'd0, rsp_err[0]}, 32'd0);
    txn(0, 1, F3_SW, 32'h10, 32'hDEADBEEF, 32'd0, 0, "sw10");
    txn(0, 0, F3_LW, 32'h10, 32'd0, 32'hDEADBEEF, 0, "lw10");
    txn(0, 1, F3_SB, 32'h11, 32'h55, 32'd0, 0, "sb11");
    txn(0, 0, F3_LW, 32'h10, 32'd0, 32'hDEAD55EF, 0, "lw10b");
    txn(0, 0, F3_LB, 32'h13, 32'd0, 32'hFFFFFFDE, 0, "lb13");
    txn(0, 0, F3_LBU, 32'h13, 32'd0, 32'h000000DE, 0, "lbu13");
    txn(0, 0, F3_LH, 32'h12, 32'd0, 32'hFFFFDEAD, 0, "lh12");
    txn(0, 0, F3_LHU, 32'h10, 32'd0, 32'h000055EF, 0, "lhu10");
    txn(0, 0, F3_LW, 32'h12, 32'd0, 32'd0, 1, "lw12");
    txn(0, 1, F3_SH, 32'h13, 32'hFFFF, 32'd0, 1, "sh13");
    txn(0, 0, 3'b011, 32'h10, 32'd0, 32'd0, 1, "ld011");
    txn(0, 1, 3'b100, 32'h10, 32'h0, 32'd0, 1, "st100");
    txn(0, 0, F3_LW, 32'h10, 32'd0, 32'hDEAD55EF, 0, "lw10c");
    txn(0, 1, F3_SW, 32'h0, 32'h11111111, 32'd0, 0, "sw0");
    txn(0, 0, F3_LW, 32'h1000, 32'd0, 32'd0, 1, "lw1000");
    txn(0, 1, F3_SW, 32'h1000, 32'h22222222, 32'd0, 1, "sw1000");
    txn(0, 0, F3_LW, 32'h0, 32'd0, 32'h11111111, 0, "lw0");
    // backpressure with a second request waiting
    rsp_ready[0] = 0;
    issue(0, 0, F3_LW, 32'h10, 32'd0);
    req_funct3[0] = F3_LHU; req_valid[0] = 1;
    wait_rsp(0, n);
    chk("bp.lat", n, 32'd3);
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", {31'd0, rsp_valid[0]}, 32'd1);
      chk("bp.rd", rsp_rdata[0], 32'hDEAD55EF);
      chk("bp.req_ready", {31'd0, req_ready[0]}, 32'd0);
      tick();
    end
    rsp_ready[0] = 1;
    tick();
    chk("bp.released", {31'd0, req_ready[0]}, 32'd1);
    tick();
    chk("bp.accept2", {31'd0, req_ready[0]}, 32'd0);
    req_valid[0] = 0;
    wait_rsp(0, n);
    chk("bp2.lat", n, 32'd3);
    chk("bp2.rd", rsp_rdata[0], 32'h000055EF);
    tick();
    // reset during WAIT, ACCESS and RESP
    txn(0, 1, F3_SW, 32'h20, 32'hCAFEF00D, 32'd0, 0, "sw20");
    issue(0, 1, F3_SW, 32'h20, 32'h12345678);
    tick();
    reset = 1; tick(); reset = 0;
    chk("rstw.valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("rstw.req_ready", {31'd0, req_ready[0]}, 32'd1);
    txn(0, 0, F3_LW, 32'h20, 32'd0, 32'hCAFEF00D, 0, "lw20a");
    issue(0, 1, F3_SW, 32'h20, 32'h12345678);
    tick(); tick();
    reset = 1; tick(); reset = 0;
    chk("rsta.valid", {31'd0, rsp_valid[0]}, 32'd0);
    txn(0, 0, F3_LW, 32'h20, 32'd0, 32'hCAFEF00D, 0, "lw20b");
    rsp_ready[0] = 0;
    issue(0, 0, F3_LW, 32'h10, 32'd0);
    wait_rsp(0, n);
    chk("rstr.valid_before", {31'd0, rsp_valid[0]}, 32'd1);
    reset = 1; tick(); reset = 0;
    chk("rstr.valid", {31'd0, rsp_valid[0]}, 32'd0);
    chk("rstr.req_ready", {31'd0, req_ready[0]}, 32'd1);
    // zero wait states
    txn(1, 1, F3_SW, 32'h40, 32'hA5A5A5A5, 32'd0, 0, "w0.sw40");
    txn(1, 0, F3_LW, 32'h40, 32'd0, 32'hA5A5A5A5, 0, "w0.lw40");
    txn(1, 1, F3_SH, 32'h42, 32'h1234, 32'd0, 0, "w0.sh42");
    txn(1, 0, F3_LB, 32'h41, 32'd0, 32'hFFFFFFA5, 0, "w0.lb41");
    txn(1, 0, F3_LW, 32'h40, 32'd0, 32'h1234A5A5, 0, "w0.lw40b");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
